adacc01_3v3_model: RTL and testbench

//  Behavioural model of a 10-bit, 3.3 V resistor-string DAC macro (adacc01_3v3) for mixed-signal sim.

---
 rtl/adacc_pkg.sv | 37 +++
 rtl/adacc01_3v3_supply_mon.sv | 32 +++
 rtl/adacc01_3v3_model.sv | 85 ++++++++
 tb/tb_adacc01_3v3_model.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/adacc_pkg.sv
// ---------------------------------------------------------------------------
// adacc_pkg
//   Shared constants and helpers for the adacc01_3v3 resistor-string DAC
//   behavioural model.
//   DWIDTH_DEF   default code width
//   FULL_SCALE   full-scale code for the default width (2**DWIDTH_DEF-1)
//   code_to_volt ideal transfer: code -> volts between the two references
//   volt_clamp   clamp a voltage into a [lo, hi] window
// ---------------------------------------------------------------------------
package adacc_pkg;

   localparam int          DWIDTH_DEF = 10;
   localparam int unsigned FULL_SCALE = (32'd1 << DWIDTH_DEF) - 32'd1;

   localparam real VDD_MIN_DEF  = 1.62;
   localparam real VDDA_MIN_DEF = 2.97;

   // Pure real arithmetic, no rounding. Code 0 lands exactly on vrefl and
   // full scale lands exactly on vrefh; vrefh < vrefl gives an inverted ramp.
   function automatic real code_to_volt(input int unsigned code,
                                        input real         vrefh,
                                        input real         vrefl,
                                        input int unsigned full_scale);
      return vrefl + (real'(code) * (vrefh - vrefl)) / real'(full_scale);
   endfunction

   function automatic real volt_clamp(input real v,
                                      input real lo,
                                      input real hi);
      real r;
      r = v;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/adacc01_3v3_supply_mon.sv
// ---------------------------------------------------------------------------
// adacc01_3v3_supply_mon
//   Combinational supply-valid detector for the DAC model. Re-evaluates on
//   any change of the real-valued rails, no clock involved.
//   vdd_i, vss_i    digital supply / ground (volts)
//   vdda_i, vssa_i  analog supply / ground (volts)
//   pwr_ok_o        1 when both differential supplies are at or above minimum
// ---------------------------------------------------------------------------
module adacc01_3v3_supply_mon
   import adacc_pkg::*;
#(
   parameter real VDD_MIN  = VDD_MIN_DEF,
   parameter real VDDA_MIN = VDDA_MIN_DEF
) (
   input  real  vdd_i,
   input  real  vss_i,
   input  real  vdda_i,
   input  real  vssa_i,
   output logic pwr_ok_o
);

   logic vdd_ok;
   logic vdda_ok;

   // A supply exactly at its minimum still counts as valid.
   always_comb begin
      vdd_ok   = ((vdd_i - vss_i) >= VDD_MIN);
      vdda_ok  = ((vdda_i - vssa_i) >= VDDA_MIN);
      pwr_ok_o = vdd_ok && vdda_ok;
   end

endmodule

// File: rtl/adacc01_3v3_model.sv
// ---------------------------------------------------------------------------
// adacc01_3v3_model
//   Behavioural model of a 3.3 V resistor-string DAC macro. A digital core
//   drives D/EN; OUT is a real-valued voltage for analog sinks.
//   clk     sampling clock for D/EN
//   reset   asynchronous active-low reset
//   EN      converter enable (sampled)
//   D       unsigned input code (sampled while EN=1)
//   VDD/VSS, VDDA/VSSA   real-valued supplies
//   VREFH/VREFL          real-valued references
//   OUT     analog output voltage, clamped to [VSSA, VDDA]
// ---------------------------------------------------------------------------
module adacc01_3v3_model
   import adacc_pkg::*;
#(
   parameter int  DWIDTH   = DWIDTH_DEF,
   parameter real VDD_MIN  = VDD_MIN_DEF,
   parameter real VDDA_MIN = VDDA_MIN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              EN,
   input  logic [DWIDTH-1:0] D,
   input  real               VDD,
   input  real               VDDA,
   input  real               VREFH,
   input  real               VREFL,
   input  real               VSS,
   input  real               VSSA,
   output real               OUT
);

   localparam int unsigned FULL_SCALE_L = (32'd1 << DWIDTH) - 32'd1;

   logic [DWIDTH-1:0] code_q, code_d;
   logic              en_q, en_d;
   logic              pwr_ok;
   logic              d_valid;
   real               v_xfer;

   adacc01_3v3_supply_mon #(
      .VDD_MIN  (VDD_MIN),
      .VDDA_MIN (VDDA_MIN)
   ) u_supply_mon (
      .vdd_i    (VDD),
      .vss_i    (VSS),
      .vdda_i   (VDDA),
      .vssa_i   (VSSA),
      .pwr_ok_o (pwr_ok)
   );

   // A code with any X/Z bit is ignored so the ladder keeps the last good
   // code instead of propagating an unknown onto the analog net.
   always_comb begin
      d_valid = !$isunknown(D);
      en_d    = EN;
      code_d  = code_q;
      if (EN && d_valid) begin
         code_d = D;
      end
   end

   // Disabling keeps code_q so re-enabling restores the previous level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         code_q <= '0;
         en_q   <= 1'b0;
      end else begin
         code_q <= code_d;
         en_q   <= en_d;
      end
   end

   // Output path is purely combinational from the registers and the rails,
   // so reference or supply moves show up without a clock.
   always_comb begin
      v_xfer = code_to_volt(32'(code_q), VREFH, VREFL, FULL_SCALE_L);
      if (!en_q || !pwr_ok) begin
         OUT = VSSA;
      end else begin
         OUT = volt_clamp(v_xfer, VSSA, VDDA);
      end
   end

endmodule

// File: tb/tb_adacc01_3v3_model.sv
module tb_adacc01_3v3_model;

   logic       clk;
   logic       reset;
   logic       en;
   logic [9:0] d;
   real        vdd, vdda, vrefh, vrefl, vss, vssa;
   real        out_v;

   int n_chk;
   int n_bad;

   // reference state: what the converter currently "holds"
   int m_code;
   bit m_en;

   adacc01_3v3_model u_dut (
      .clk   (clk),
      .reset (reset),
      .EN    (en),
      .D     (d),
      .VDD   (vdd),
      .VDDA  (vdda),
      .VREFH (vrefh),
      .VREFL (vrefl),
      .VSS   (vss),
      .VSSA  (vssa),
      .OUT   (out_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour: clear on reset, take EN every edge, take the code
   // only when enabled and fully known.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_code = 0;
         m_en   = 1'b0;
      end else begin
         m_en = en;
         if (en && !$isunknown(d)) m_code = int'(d);
      end
   end

   function automatic real model_out();
      real v;
      if (!reset || !m_en) return vssa;
      if ((vdd - vss) < 1.62 || (vdda - vssa) < 2.97) return vssa;
      v = vrefl + m_code * (vrefh - vrefl) / 1023.0;
      if (v > vdda) v = vdda;
      if (v < vssa) v = vssa;
      return v;
   endfunction

   task automatic check_val(input string tag, input real got, input real exp);
      real diff;
      n_chk++;
      diff = got - exp;
      if (diff < 0.0) diff = -diff;
      if (diff > 1.0e-5) begin
         n_bad++;
         $display("FAIL %s: got=%f expected=%f", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   real exp_seq[6];
   real v_sel[4];
   real vd_sel[3];

   initial begin
      n_chk = 0;
      n_bad = 0;
      exp_seq = '{3.28387, 3.28710, 3.29032, 3.29355, 3.29677, 3.30000};
      v_sel   = '{2.5, 2.97, 3.3, 3.6};
      vd_sel  = '{1.5, 1.62, 1.8};

      // 1: held in reset, enabled, full scale -> VSSA regardless of clk
      reset = 1'b0; en = 1'b1; d = 10'h3FF;
      vdd = 1.8; vdda = 3.3; vss = 0.0; vssa = 0.0; vrefh = 3.3; vrefl = 0.0;
      #1;
      check_val("reset_t0", out_v, 0.0);
      tick(); tick(); tick();
      check_val("reset_clk", out_v, 0.0);
      #2 reset = 1'b1;

      // 2: top-end codes, one per edge
      for (int i = 0; i < 6; i++) begin
         d = 10'h3FA + 10'(i);
         tick();
         check_val($sformatf("top_code_%0d", i), out_v, exp_seq[i]);
      end

      // 3: zero code sits on VREFL, mid code with raised VREFL
      d = 10'h000;
      tick();
      check_val("code0_vrefl0", out_v, 0.0);
      vrefl = 0.3;
      #1;
      check_val("code0_vrefl03", out_v, 0.3);
      d = 10'h200;
      tick();
      check_val("mid_code", out_v, 1.80147);
      vrefl = 0.0;
      #1;

      // 4: EN falls -> VSSA only at the next edge, re-enable restores
      d = 10'h3FF;
      tick();
      check_val("full_scale", out_v, 3.3);
      en = 1'b0;
      #1;
      check_val("en_low_pre_edge", out_v, 3.3);
      tick();
      check_val("en_low", out_v, 0.0);
      en = 1'b1;
      tick();
      check_val("en_high", out_v, 3.3);

      // 5: supply droop is immediate, recovery restores the level
      vdda = 2.5;
      #1;
      check_val("vdda_low", out_v, 0.0);
      vdda = 3.3;
      #1;
      check_val("vdda_back", out_v, 3.3);
      vdd = 1.5;
      #1;
      check_val("vdd_low", out_v, 0.0);
      vdd = 1.62;
      #1;
      check_val("vdd_at_min", out_v, 3.3);
      vdd = 1.8; vdda = 2.97;
      #1;
      check_val("vdda_at_min", out_v, 2.97);
      vdda = 3.3;

      // clamp and inverted transfer
      vrefh = 4.0;
      #1;
      check_val("clamp_hi", out_v, 3.3);
      vrefh = 0.0; vrefl = 3.3;
      #1;
      check_val("inv_fs", out_v, 0.0);
      d = 10'h000;
      tick();
      check_val("inv_zero", out_v, 3.3);
      vrefh = 3.3; vrefl = 0.0;

      // 6: unknown code after a valid one holds the last good code
      d = 10'h100;
      tick();
      check_val("code_100", out_v, 0.82580);
      d = 10'bx;
      tick();
      check_val("code_x_hold", out_v, model_out());
      tick();
      check_val("code_x_hold2", out_v, model_out());

      // mid-cycle async reset, then first edge after release samples
      d = 10'h155;
      #2 reset = 1'b0;
      #1;
      check_val("async_rst", out_v, 0.0);
      #1 reset = 1'b1;
      tick();
      check_val("post_rst", out_v, 3.3 * 341.0 / 1023.0);

      // randomized sweep against the reference
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 3) != 0);
         d  = 10'($urandom);
         if ($urandom_range(0, 15) == 0) d = 10'bx;
         if ($urandom_range(0, 7) == 0) begin
            vrefh = $urandom_range(0, 4000) / 1000.0;
            vrefl = $urandom_range(0, 4000) / 1000.0;
         end
         if ($urandom_range(0, 9) == 0) vdda = v_sel[$urandom_range(0, 3)];
         if ($urandom_range(0, 9) == 0) vdd = vd_sel[$urandom_range(0, 2)];
         #1;
         check_val("rnd_comb", out_v, model_out());
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b0;
            #1;
            check_val("rnd_rst", out_v, model_out());
            reset = 1'b1;
         end
         tick();
         check_val("rnd_clk", out_v, model_out());
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
